// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer
// Description : Initiator side of the register-unit write/read interface.
//               Buffers 32-bit RISC-V R-type instructions arriving over a
//               valid/ready handshake and replays each one as a READ cycle
//               (operand fetch / ALU settle) followed by a WRITE cycle
//               (register-unit write enable). Counts retired and illegal
//               instructions.
// Ports       :
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   instr        in   32     instruction word
//   instr_valid  in   1      instr is valid this cycle
//   instr_ready  out  1      buffer can accept (not full)
//   rs1/rs2/rd   out  5      register indices decoded from the current ir
//   RUWr         out  1      register unit write enable (WRITE, legal, rd!=0)
//   alu_op       out  4      {ir[30], ir[14:12]}
//   busy         out  1      sequencer active or buffer holds instructions
//   illegal      out  1      one-cycle pulse in WRITE for non R-type opcode
//   retired_cnt  out  CNT_W  instructions completed (wrapping)
//   illegal_cnt  out  CNT_W  illegal instructions completed (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer #(
  parameter int         FIFO_DEPTH = 2,
  parameter int         CNT_W      = 16,
  parameter logic [6:0] OPC_RTYPE  = 7'b0110011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             RUWr,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int                c_PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]  c_FIFO_FULL = (c_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]  c_CNT_ONE   = (c_PTR_W+1)'(1);
  localparam logic [CNT_W-1:0]  c_CTR_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Instruction buffer
  // --------------------------------------------------------------------------
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Current instruction register and decode
  logic [31:0]      r_ir;
  logic             w_legal;
  logic             w_rd_nonzero;
  logic             w_ruwr;
  logic             w_illegal;
  logic             w_retire;

  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_illegal_cnt;

  assign w_full  = (r_count == c_FIFO_FULL);
  assign w_empty = (r_count == '0);

  // Acceptance depends only on occupancy, so instr_ready never combinationally
  // follows instr_valid.
  assign w_push  = instr_valid && !w_full;

  assign w_legal      = (r_ir[6:0] == OPC_RTYPE);
  assign w_rd_nonzero = (r_ir[11:7] != 5'd0);

  // --------------------------------------------------------------------------
  // FSM next-state and per-state outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ruwr      = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        // One settle cycle for asynchronous register reads and the ALU.
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_retire  = 1'b1;
        w_illegal = !w_legal;
        // Writes to x0 are suppressed but the instruction still retires.
        w_ruwr    = w_legal && w_rd_nonzero;
        // Chain straight into the next READ so back-to-back instructions
        // retire every two cycles.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer storage: data array needs no reset, the pointers/count define
  // which entries are meaningful.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Instruction register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= '0;
    end else if (w_pop) begin
      r_ir <= r_mem[r_rd_ptr];
    end
  end

  // --------------------------------------------------------------------------
  // Retirement counters (wrap, never saturate)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
      r_illegal_cnt <= '0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + c_CTR_ONE;
      if (w_illegal) begin
        r_illegal_cnt <= r_illegal_cnt + c_CTR_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign instr_ready = !w_full;
  assign rs1         = r_ir[19:15];
  assign rs2         = r_ir[24:20];
  assign rd          = r_ir[11:7];
  assign alu_op      = {r_ir[30], r_ir[14:12]};
  assign RUWr        = w_ruwr;
  assign illegal     = w_illegal;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign retired_cnt = r_retired_cnt;
  assign illegal_cnt = r_illegal_cnt;

  // funct7 bits other than ir[30] carry no meaning for this unit.
  logic w_unused_ir;
  assign w_unused_ir = &{1'b0, r_ir[31], r_ir[29:25]};

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Self-checking bench for regfile_sequencer. Directed scenarios
//               plus a randomized stream checked against an in-order queue
//               model of retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

  // Narrow counters so the random stream exercises counter wrap-around.
  localparam int         CNT_W = 4;
  localparam logic [6:0] OPC   = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      instr = '0;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             RUWr;
  logic [3:0]       alu_op;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(
    .FIFO_DEPTH (2),
    .CNT_W      (CNT_W),
    .OPC_RTYPE  (OPC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .RUWr        (RUWr),
    .alu_op      (alu_op),
    .busy        (busy),
    .illegal     (illegal),
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_checks++;
    if ({rs1, rs2, rd, alu_op} !== 19'd0) begin
      n_fail++; $display("FAIL reset_fields: got %h expected 0", {rs1, rs2, rd, alu_op});
    end
    n_checks++;
    if ({RUWr, illegal, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {RUWr, illegal, busy});
    end
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", instr_ready);
    end
    n_checks++;
    if ({retired_cnt, illegal_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", retired_cnt, illegal_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, instr_ready, RUWr} !== 3'b010) begin
      n_fail++; $display("FAIL reset_release: got busy/ready/RUWr=%b expected 010", {busy, instr_ready, RUWr});
    end
  endtask

  // --------------------------------------------------------------------------
  // Single instruction pushed into an idle, empty sequencer; expected field
  // values are given explicitly by the caller.
  task automatic test_single(input string nm, input logic [31:0] ins,
                             input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                             input logic [4:0] e_rd, input logic [3:0] e_alu,
                             input logic e_wr, input logic e_ill);
    do_reset();
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);                 // pushed at the edge just passed
    instr_valid = 1'b0;
    n_checks++;
    if ({busy, RUWr, illegal} !== 3'b100) begin
      n_fail++; $display("FAIL %s_queued: busy/RUWr/illegal got %b expected 100", nm, {busy, RUWr, illegal});
    end
    @(negedge clk);                 // READ cycle
    n_checks++;
    if ({rs1, rs2, rd, alu_op} !== {e_rs1, e_rs2, e_rd, e_alu}) begin
      n_fail++; $display("FAIL %s_read_fields: got rs1=%0d rs2=%0d rd=%0d alu=%b expected rs1=%0d rs2=%0d rd=%0d alu=%b",
                         nm, rs1, rs2, rd, alu_op, e_rs1, e_rs2, e_rd, e_alu);
    end
    n_checks++;
    if ({RUWr, illegal} !== 2'b00) begin
      n_fail++; $display("FAIL %s_read_ctrl: RUWr/illegal got %b expected 00", nm, {RUWr, illegal});
    end
    @(negedge clk);                 // WRITE cycle
    n_checks++;
    if ({RUWr, illegal} !== {e_wr, e_ill}) begin
      n_fail++; $display("FAIL %s_write_ctrl: RUWr/illegal got %b expected %b", nm, {RUWr, illegal}, {e_wr, e_ill});
    end
    n_checks++;
    if (retired_cnt !== '0) begin
      n_fail++; $display("FAIL %s_early_retire: retired_cnt got %0d expected 0", nm, retired_cnt);
    end
    @(negedge clk);                 // back to IDLE
    n_checks++;
    if ({RUWr, illegal, busy} !== 3'b000) begin
      n_fail++; $display("FAIL %s_after: RUWr/illegal/busy got %b expected 000", nm, {RUWr, illegal, busy});
    end
    n_checks++;
    if (retired_cnt !== CNT_W'(1) || illegal_cnt !== CNT_W'(e_ill)) begin
      n_fail++; $display("FAIL %s_counts: got retired=%0d illegal=%0d expected 1/%0d", nm, retired_cnt, illegal_cnt, e_ill);
    end
  endtask

  // --------------------------------------------------------------------------
  // Five distinct legal instructions with instr_valid held high.
  task automatic test_back_to_back();
    logic [31:0] list [5];
    int pushed = 0;
    int nret   = 0;
    int last   = 0;
    bit saw_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      list[i]       = $urandom;
      list[i][6:0]  = OPC;
      list[i][11:7] = 5'(i + 1);
    end
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (pushed < 5) begin
        instr       = list[pushed];
        instr_valid = 1'b1;
        if (instr_ready) pushed++;
        else saw_full = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
      if (RUWr === 1'b1) begin
        n_checks++;
        if (nret >= 5) begin
          n_fail++; $display("FAIL b2b_extra_write: got write rd=%0d expected none", rd);
        end else if ({rs1, rs2, rd} !== {list[nret][19:15], list[nret][24:20], list[nret][11:7]}) begin
          n_fail++; $display("FAIL b2b_order: got rs1=%0d rs2=%0d rd=%0d expected rs1=%0d rs2=%0d rd=%0d",
                             rs1, rs2, rd, list[nret][19:15], list[nret][24:20], list[nret][11:7]);
        end
        if (nret > 0) begin
          n_checks++;
          if (cyc - last != 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected 2", cyc - last);
          end
        end
        last = cyc;
        nret++;
      end
    end
    instr_valid = 1'b0;
    n_checks++;
    if (saw_full !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_drop: got never-full expected instr_ready low");
    end
    n_checks++;
    if (nret != 5 || retired_cnt !== CNT_W'(5)) begin
      n_fail++; $display("FAIL b2b_count: got writes=%0d retired=%0d expected 5/5", nret, retired_cnt);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reset asserted in the second WRITE cycle, two instructions still buffered.
  task automatic test_reset_midop();
    int pushed = 0;
    int writes = 0;
    bit hit    = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
      if (pushed < 4) begin
        instr       = {7'd0, 5'd2, 5'd1, 3'd0, 5'(pushed + 10), OPC};
        instr_valid = 1'b1;
        if (instr_ready) pushed++;
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
      if (RUWr === 1'b1) begin
        writes++;
        if (writes == 2) hit = 1'b1;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL midop_reach: got %0d writes expected 2 within budget", writes);
    end
    n_checks++;
    if (retired_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL midop_pre_cnt: got %0d expected 1", retired_cnt);
    end
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_checks++;
    if ({RUWr, illegal, rs1, rs2, rd, alu_op} !== 21'd0) begin
      n_fail++; $display("FAIL midop_async: got %h expected 0", {RUWr, illegal, rs1, rs2, rd, alu_op});
    end
    n_checks++;
    if ({retired_cnt, illegal_cnt} !== '0) begin
      n_fail++; $display("FAIL midop_cnt: got %0d/%0d expected 0/0", retired_cnt, illegal_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({RUWr, busy, instr_ready} !== 3'b001 || retired_cnt !== '0) begin
        n_fail++; $display("FAIL midop_after: RUWr/busy/ready got %b retired=%0d expected 001/0",
                           {RUWr, busy, instr_ready}, retired_cnt);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Random stream: every retirement is compared with the oldest accepted
  // instruction; expected outputs follow directly from the instruction fields.
  task automatic test_random(input int n, input int pct);
    logic [31:0]      exp_q [$];
    logic [31:0]      e;
    logic [CNT_W-1:0] m_ret = '0;
    logic [CNT_W-1:0] m_ill = '0;
    logic [CNT_W-1:0] p_ret;
    logic [18:0]      p_fields;
    logic             p_wr, p_ill, e_wr, e_ill;
    int pushed = 0, retired = 0, last = -10;
    bit pending = 1'b0;
    int limit = n * 12 + 50;
    do_reset();
    p_ret = retired_cnt; p_fields = {rs1, rs2, rd, alu_op}; p_wr = RUWr; p_ill = illegal;
    for (int cyc = 0; cyc < limit && retired < n; cyc++) begin
      @(negedge clk);
      if (retired_cnt !== p_ret) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious_retire: got retire with empty model expected none");
        end else begin
          e     = exp_q.pop_front();
          e_ill = (e[6:0] != OPC);
          e_wr  = !e_ill && (e[11:7] != 5'd0);
          m_ret = m_ret + 1'b1;
          if (e_ill) m_ill = m_ill + 1'b1;
          if ({p_fields, p_wr, p_ill} !== {e[19:15], e[24:20], e[11:7], e[30], e[14:12], e_wr, e_ill}) begin
            n_fail++; $display("FAIL rand_write_phase: got %h wr=%b ill=%b expected %h wr=%b ill=%b (instr %h)",
                               p_fields, p_wr, p_ill, {e[19:15], e[24:20], e[11:7], e[30], e[14:12]}, e_wr, e_ill, e);
          end
          n_checks++;
          if (retired_cnt !== m_ret || illegal_cnt !== m_ill) begin
            n_fail++; $display("FAIL rand_counters: got %0d/%0d expected %0d/%0d", retired_cnt, illegal_cnt, m_ret, m_ill);
          end
          n_checks++;
          if (cyc - last < 2) begin
            n_fail++; $display("FAIL rand_spacing: got %0d cycles expected >=2", cyc - last);
          end
          last = cyc;
          retired++;
        end
      end else begin
        n_checks++;
        if ({p_wr, p_ill} !== 2'b00) begin
          n_fail++; $display("FAIL rand_stray_pulse: RUWr/illegal got %b expected 00 outside retirement", {p_wr, p_ill});
        end
      end
      p_ret = retired_cnt; p_fields = {rs1, rs2, rd, alu_op}; p_wr = RUWr; p_ill = illegal;
      // Drive the next handshake; a refused word is held unchanged.
      if (!pending) begin
        if (pushed < n && $urandom_range(99) < pct) begin
          instr = $urandom;
          if ($urandom_range(3) != 0) instr[6:0] = OPC;
          if ($urandom_range(5) == 0) instr[11:7] = 5'd0;
          instr_valid = 1'b1;
        end else begin
          instr_valid = 1'b0;
        end
      end
      if (instr_valid && instr_ready) begin
        exp_q.push_back(instr);
        pushed++;
        pending = 1'b0;
      end else begin
        pending = instr_valid;
      end
    end
    instr_valid = 1'b0;
    n_checks++;
    if (retired != n) begin
      n_fail++; $display("FAIL rand_timeout: got %0d retired expected %0d", retired, n);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, instr_ready, RUWr} !== 3'b010) begin
      n_fail++; $display("FAIL rand_drain: busy/ready/RUWr got %b expected 010", {busy, instr_ready, RUWr});
    end
  endtask

  initial begin
    test_reset();
    test_single("add",     32'h002081B3, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 1'b0);
    test_single("sub",     32'h407302B3, 5'd6, 5'd7, 5'd5, 4'b1000, 1'b1, 1'b0);
    test_single("add_x0",  32'h00208033, 5'd1, 5'd2, 5'd0, 4'b0000, 1'b0, 1'b0);
    test_single("addi",    32'h00108093, 5'd1, 5'd1, 5'd1, 4'b0000, 1'b0, 1'b1);
    test_back_to_back();
    test_reset_midop();
    test_random(60, 70);
    test_random(40, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Initiator side of the register-unit write/read interface.
- Accepts 32-bit RISC-V R-type instructions through a valid/ready handshake and buffers them in a small FIFO.
- Sequences each instruction as a read phase followed by a write phase, driving rs1/rs2/rd/RUWr and an ALU op code to the register unit.
- Sits between instruction fetch and the register unit; counts retired and illegal instructions.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.
- CNT_W, 16, width of the retired and illegal counters.
- OPC_RTYPE, 7'b0110011, opcode accepted as legal R-type.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  FIFO can accept; equals !full.
- rs1  out  5  source register 1 index, ir[19:15].
- rs2  out  5  source register 2 index, ir[24:20].
- rd  out  5  destination register index, ir[11:7].
- RUWr  out  1  register unit write enable.
- alu_op  out  4  {ir[30], ir[14:12]}.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- illegal  out  1  one-cycle pulse when the instruction in WRITE has an illegal opcode.
- retired_cnt  out  CNT_W  instructions completed, legal and illegal.
- illegal_cnt  out  CNT_W  illegal instructions seen.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFO empty, state IDLE, ir = 0, both counters = 0.
  - RUWr, illegal and busy = 0; instr_ready = 1.
  - rs1, rs2, rd and alu_op = 0.
- Push: a FIFO write occurs at a rising edge when instr_valid && instr_ready. Data presented while instr_ready = 0 is ignored; the source must hold it.
- FSM states:
  - IDLE: if the FIFO is non-empty, load the head into ir, pop, and go to READ. Otherwise stay in IDLE.
  - READ: rs1/rs2/rd/alu_op are driven from ir, RUWr = 0. This is one settle cycle for the asynchronous reads and the ALU. Next state is always WRITE.
  - WRITE:
    - RUWr = 1 iff ir[6:0] == OPC_RTYPE and rd != 0.
    - illegal = 1 iff ir[6:0] != OPC_RTYPE.
    - At the edge leaving WRITE, retired_cnt increments by 1, and illegal_cnt increments by 1 if the instruction is illegal.
    - If the FIFO is non-empty, load the head into ir, pop, and go to READ. Otherwise go to IDLE.
- RUWr and illegal are decodes of the state register and ir only; no input-to-output combinational path exists.
- Latency: an instruction pushed at edge N into an empty FIFO with the FSM in IDLE:
  - ir loads at N+1 (READ during the following cycle).
  - RUWr is high during the cycle after N+2.
  - The write is committed by the register unit at edge N+3.
- Throughput: back-to-back instructions retire every 2 cycles.
- FIFO: simultaneous push and pop keep the count unchanged. Push when full cannot occur because instr_ready is low. Read and write pointers wrap modulo FIFO_DEPTH.
- rd = 0 with a legal opcode: retires normally, RUWr stays 0, no illegal pulse.
- Counters wrap at 2^CNT_W - 1 -> 0 and never saturate.
- Reset mid-operation: RUWr deasserts immediately. The in-flight and buffered instructions are discarded and no partial write is reissued.
- Fields in ir other than opcode, rs1, rs2, rd, funct3 and ir[30] are ignored.

Test Plan:
- add x3,x1,x2 (0x002081B3) pushed once from idle:
  - READ cycle: rs1=1, rs2=2, rd=3, alu_op=0, RUWr=0.
  - Next cycle: RUWr=1 for exactly 1 cycle.
  - retired_cnt=1.
- sub x5,x6,x7 (0x407302B3) -> rs1=6, rs2=7, rd=5, alu_op=4'b1000, RUWr pulse 1 cycle.
- add x0,x1,x2 (0x00208033) -> RUWr never asserts, illegal=0, retired_cnt increments to 1.
- addi (0x00108093) -> RUWr=0, illegal pulses 1 cycle, illegal_cnt=1, retired_cnt=1.
- Hold instr_valid high for 5 distinct legal instructions from reset:
  - instr_ready drops when the FIFO is full.
  - All 5 retire in order with RUWr every 2nd cycle.
  - retired_cnt=5 and no instruction is lost or duplicated.
- Assert rst_n=0 during a WRITE cycle with 2 instructions buffered:
  - RUWr falls asynchronously; outputs and counters return to 0.
  - After release, busy=0 and instr_ready=1.
